// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// port indices and default widths.
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_READ_LATENCY = 1;
    localparam int CNT_W            = 4;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way round-robin pick: a lone requester wins, and under
// contention the port that did not win last time goes first.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_win
        assign win[gi] = req[gi] & (~req[1 - gi] | (last != 1'(gi)));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (port 0) and a
// loader/debug master (port 1), one transaction in flight at a time.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              pipe_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t             state_reg;
    logic               last_reg;
    logic               winner_reg;
    logic               we_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [1:0]         done_reg;
    logic               busy_reg;
    logic               mem_read_reg;
    logic               mem_write_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic [DATA_W-1:0]  rdata_reg [2];

    logic [1:0]         req_vec;
    logic [1:0]         win;
    logic [1:0]         gnt;
    logic [1:0]         rdata_load;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    assign req_vec = {p1_req, p0_req};

    rr_arbiter2 u_rr (
        .req  (req_vec),
        .last (last_reg),
        .win  (win)
    );

    assign sel_we    = win[1] ? p1_we    : p0_we;
    assign sel_addr  = win[1] ? p1_addr  : p0_addr;
    assign sel_wdata = win[1] ? p1_wdata : p0_wdata;

    // Grant is issued in the same cycle the request is seen; masking with
    // reset keeps it low while the block is held in reset.
    assign gnt = (reset && state_reg == ST_IDLE) ? win : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            last_reg      <= PORT_LOAD;
            winner_reg    <= PORT_PIPE;
            we_reg        <= 1'b0;
            cnt_reg       <= '0;
            done_reg      <= 2'b00;
            busy_reg      <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req_vec) begin
                        winner_reg    <= win[1];
                        we_reg        <= sel_we;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_wdata;
                        mem_write_reg <= sel_we;
                        mem_read_reg  <= ~sel_we;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    mem_addr_reg  <= '0;
                    mem_wdata_reg <= '0;
                    if (we_reg) begin
                        done_reg  <= port_onehot(winner_reg);
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg   <= CNT_W'(READ_LATENCY - 1);
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        done_reg  <= port_onehot(winner_reg);
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 2'b00;
                    last_reg  <= winner_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Each port keeps its own read-data register so one port's traffic never
    // disturbs the other's last result.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rdata_load[gi] = (state_reg == ST_WAIT) && (cnt_reg == '0) &&
                                (winner_reg == 1'(gi));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata_reg[gi] <= '0;
            end else if (rdata_load[gi]) begin
                rdata_reg[gi] <= mem_rdata;
            end
        end
    end

    assign p0_gnt     = gnt[0];
    assign p1_gnt     = gnt[1];
    assign p0_done    = done_reg[0];
    assign p1_done    = done_reg[1];
    assign p0_rdata   = rdata_reg[0];
    assign p1_rdata   = rdata_reg[1];
    assign pipe_stall = p0_req & ~p0_done;
    assign mem_read   = mem_read_reg;
    assign mem_write  = mem_write_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected
// grants, memory strobes and completions; a negedge monitor pops and compares.
module tb_dmem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_done, p1_gnt, p1_done, pipe_stall;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .pipe_stall(pipe_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: word array plus a LAT-deep read pipeline; poison when idle.
    logic        mem_init = 1'b1;
    logic [31:0] mem [64];
    logic [31:0] rpipe [LAT];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 8) ? 32'h1234_5678 : 32'h1000_0000 + 32'(i);
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        rpipe[0] <= mem_read ? mem[mem_addr[7:2]] : 32'h0BAD_F00D;
        for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    typedef struct { int port; int cyc; } gnt_exp_t;
    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } mem_exp_t;
    typedef struct { int port; bit rd; logic [31:0] data; int cyc; } done_exp_t;

    gnt_exp_t  gnt_q[$];
    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    gnt_exp_t  g_cur;
    mem_exp_t  m_cur;
    done_exp_t d_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        miscompares++;
        $display("FAIL %s: protocol violation at cycle %0d", name, cyc);
    endtask

    task automatic exp_gnt(input int p, input int c);
        gnt_q.push_back('{p, c});
    endtask

    task automatic exp_mem(input bit we, input logic [31:0] a, input logic [31:0] d, input int c);
        mem_q.push_back('{we, a, d, c});
    endtask

    task automatic exp_done(input int p, input bit rd, input logic [31:0] d, input int c);
        done_q.push_back('{p, rd, d, c});
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_strobes"}, {p0_gnt, p1_gnt, p0_done, p1_done, mem_read, mem_write, busy, pipe_stall}, 0);
        chk({name, "_mem_addr"}, mem_addr, 0);
        chk({name, "_mem_wdata"}, mem_wdata, 0);
        chk({name, "_p0_rdata"}, p0_rdata, 0);
        chk({name, "_p1_rdata"}, p1_rdata, 0);
    endtask

    task automatic port_txn(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        if (p == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 0 ? p0_done : p1_done) && n < 64);
        if (!(p == 0 ? p0_done : p1_done)) begin
            vectors++;
            miscompares++;
            $display("FAIL port%0d_timeout: no done within %0d cycles", p, n);
        end
        @(posedge clk); #1;
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (p0_gnt && p1_gnt)     flag("gnt_overlap");
            if (p0_done && p1_done)   flag("done_overlap");
            if (mem_read && mem_write) flag("strobe_overlap");
            if (pipe_stall !== (p0_req && !p0_done)) flag("pipe_stall_rule");
            if (p0_gnt || p1_gnt) begin
                if (gnt_q.size() == 0) flag("gnt_unexpected");
                else begin
                    g_cur = gnt_q.pop_front();
                    chk("gnt_port", p1_gnt, g_cur.port);
                    chk("gnt_cycle", cyc, g_cur.cyc);
                end
            end
            if (mem_read || mem_write) begin
                if (mem_q.size() == 0) flag("mem_strobe_unexpected");
                else begin
                    m_cur = mem_q.pop_front();
                    chk("mem_we", mem_write, m_cur.we);
                    chk("mem_addr", mem_addr, m_cur.addr);
                    if (m_cur.we) chk("mem_wdata", mem_wdata, m_cur.wdata);
                    chk("mem_cycle", cyc, m_cur.cyc);
                end
            end
            if (p0_done || p1_done) begin
                if (done_q.size() == 0) flag("done_unexpected");
                else begin
                    d_cur = done_q.pop_front();
                    chk("done_port", p1_done, d_cur.port);
                    chk("done_cycle", cyc, d_cur.cyc);
                    if (d_cur.rd) chk("rdata", p1_done ? p1_rdata : p0_rdata, d_cur.data);
                    $display("txn port%0d %s done at cycle %0d rdata=%08h", p1_done ? 1 : 0,
                             d_cur.rd ? "read " : "write", cyc, p1_done ? p1_rdata : p0_rdata);
                end
            end
        end
    end

    // Latency sweep: three more instances, each reading address 0x40 on port 0.
    logic [2:0]  sw_req = 3'b000;
    logic [2:0]  sw_done, sw_mem_read;
    logic [31:0] sw_rdata [3];
    logic [31:0] sw_mem_addr [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int SL = (gi == 0) ? 1 : (gi == 1) ? 2 : 15;
        logic        s_gnt, s_stall, s_p1_gnt, s_p1_done, s_mem_write, s_busy;
        logic [31:0] s_p1_rdata, s_mem_wdata, s_mem_rdata;
        logic [31:0] s_pipe [SL];

        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(SL)) u_sw (
            .clk(clk), .reset(reset),
            .p0_req(sw_req[gi]), .p0_we(1'b0), .p0_addr(32'h40), .p0_wdata(32'h0),
            .p0_gnt(s_gnt), .p0_done(sw_done[gi]), .p0_rdata(sw_rdata[gi]), .pipe_stall(s_stall),
            .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
            .p1_gnt(s_p1_gnt), .p1_done(s_p1_done), .p1_rdata(s_p1_rdata),
            .mem_read(sw_mem_read[gi]), .mem_write(s_mem_write), .mem_addr(sw_mem_addr[gi]),
            .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .busy(s_busy)
        );

        always @(posedge clk) begin
            s_pipe[0] <= sw_mem_read[gi] ? {16'hC0DE, sw_mem_addr[gi][15:0]} : 32'h0BAD_F00D;
            for (int k = 1; k < SL; k++) s_pipe[k] <= s_pipe[k-1];
        end
        assign s_mem_rdata = s_pipe[SL-1];

        always @(negedge clk) begin
            if (reset) begin
                if (s_p1_gnt || s_p1_done || s_mem_write) flag("sweep_idle_port_active");
                if (s_p1_rdata != 0 || s_mem_wdata != 0)  flag("sweep_idle_data");
                if ((s_gnt || s_stall) && !sw_req[gi])    flag("sweep_gnt_without_req");
                if (s_busy && s_gnt)                      flag("sweep_gnt_while_busy");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b;
    int got [3];
    logic [31:0] rd [3];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("in_reset");
        mem_init = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("after_reset");

        // Contention right after reset: pointer starts at 1, so p0 first.
        b = cyc;
        exp_gnt(0, b);     exp_mem(0, 32'h10, 0, b + 1); exp_done(0, 1, 32'h1000_0004, b + 5);
        exp_gnt(1, b + 6); exp_mem(0, 32'h24, 0, b + 7); exp_done(1, 1, 32'h1000_0009, b + 11);
        fork
            port_txn(0, 1'b0, 32'h10, 32'h0);
            port_txn(1, 1'b0, 32'h24, 32'h0);
        join

        // Single write on the pipeline port, with stall timing.
        b = cyc;
        exp_gnt(0, b); exp_mem(1, 32'h10, 32'hDEAD_BEEF, b + 1); exp_done(0, 0, 0, b + 2);
        fork
            port_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
            begin
                @(negedge clk); chk("stall_c0", pipe_stall, 1);
                @(negedge clk); chk("stall_c1", pipe_stall, 1);
                @(negedge clk); chk("stall_c2", pipe_stall, 0);
            end
        join

        // Loader read, latency 3.
        b = cyc;
        exp_gnt(1, b); exp_mem(0, 32'h20, 0, b + 1); exp_done(1, 1, 32'h1234_5678, b + 5);
        port_txn(1, 1'b0, 32'h20, 32'h0);

        // Both request again; p0 re-requests back-to-back and must yield to p1.
        b = cyc;
        exp_gnt(0, b);      exp_mem(0, 32'h10, 0, b + 1);              exp_done(0, 1, 32'hDEAD_BEEF, b + 5);
        exp_gnt(1, b + 6);  exp_mem(0, 32'h24, 0, b + 7);              exp_done(1, 1, 32'h1000_0009, b + 11);
        exp_gnt(0, b + 12); exp_mem(1, 32'h30, 32'hCAFE_F00D, b + 13); exp_done(0, 0, 0, b + 14);
        fork
            begin
                port_txn(0, 1'b0, 32'h10, 32'h0);
                port_txn(0, 1'b1, 32'h30, 32'hCAFE_F00D);
            end
            port_txn(1, 1'b0, 32'h24, 32'h0);
        join

        // Late arrival: p1 write shows up while p0's read is waiting.
        b = cyc;
        exp_gnt(0, b);     exp_mem(0, 32'h20, 0, b + 1);              exp_done(0, 1, 32'h1234_5678, b + 5);
        exp_gnt(1, b + 6); exp_mem(1, 32'h20, 32'h55AA_55AA, b + 7); exp_done(1, 0, 0, b + 8);
        fork
            port_txn(0, 1'b0, 32'h20, 32'h0);
            begin
                repeat (2) begin @(posedge clk); #1; end
                port_txn(1, 1'b1, 32'h20, 32'h55AA_55AA);
            end
        join
        chk("p0_rdata_kept", p0_rdata, 32'h1234_5678);
        chk("p1_rdata_kept", p1_rdata, 32'h1000_0009);

        // Reset in the middle of a p0 read: no done, everything clears.
        b = cyc;
        exp_gnt(0, b); exp_mem(0, 32'h24, 0, b + 1);
        p0_we = 1'b0; p0_addr = 32'h24; p0_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        #2;
        reset = 1'b0;
        p0_req = 1'b0;
        #1;
        chk_idle_outputs("mid_wait_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;

        b = cyc;
        exp_gnt(0, b); exp_mem(0, 32'h24, 0, b + 1); exp_done(0, 1, 32'h1000_0009, b + 5);
        port_txn(0, 1'b0, 32'h24, 32'h0);
        b = cyc;
        exp_gnt(1, b); exp_mem(0, 32'h20, 0, b + 1); exp_done(1, 1, 32'h55AA_55AA, b + 5);
        port_txn(1, 1'b0, 32'h20, 32'h0);

        // Latency sweep over 1, 2 and 15.
        b = cyc;
        sw_req = 3'b111;
        for (int k = 0; k < 3; k++) begin got[k] = -1; rd[k] = '0; end
        repeat (24) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (sw_done[k] && got[k] < 0) begin
                    got[k] = cyc - b;
                    rd[k] = sw_rdata[k];
                    sw_req[k] = 1'b0;
                    $display("txn sweep%0d read  done at offset %0d rdata=%08h", k, got[k], rd[k]);
                end
            end
        end
        chk("sweep_lat1_cycle", got[0], 3);
        chk("sweep_lat2_cycle", got[1], 4);
        chk("sweep_lat15_cycle", got[2], 17);
        for (int k = 0; k < 3; k++) chk("sweep_rdata", rd[k], 32'hC0DE_0040);

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port 0: the pipeline MEM stage (load/store);
  - port 1: a loader/debug master that preloads or inspects data memory.
- Round-robin arbitration, one outstanding transaction at a time.
- Sequences memory read/write strobes and returns read data after a fixed memory latency.
- Generates the stall the pipeline uses to hold the MEM stage until its access completes.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- READ_LATENCY, 1, cycles from the mem_read strobe to valid mem_rdata. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- p0_req  input  1  MEM-stage request; held high until the port's done pulse.
- p0_we  input  1  1 = write, 0 = read; stable while p0_req is high.
- p0_addr  input  ADDR_W  byte address, equal to the ALU result.
- p0_wdata  input  DATA_W  store data.
- p0_gnt  output  1  one-cycle pulse when port 0 wins arbitration.
- p0_done  output  1  one-cycle pulse: write committed, or p0_rdata valid.
- p0_rdata  output  DATA_W  read data, valid during the p0_done pulse of a read.
- pipe_stall  output  1  combinational: p0_req and not p0_done.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as the port 0 signals, for the loader.
- mem_read  output  1  read strobe to data memory.
- mem_write  output  1  write strobe to data memory.
- mem_addr  output  ADDR_W  address to data memory.
- mem_wdata  output  DATA_W  write data to data memory.
- mem_rdata  input  DATA_W  read data from data memory.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All strobes, gnt, done, busy and rdata outputs are 0; mem_addr and mem_wdata are 0.
  - Last-winner pointer is set to 1, so port 0 wins the first contention.
- FSM states:
  - IDLE: if any request is high, register the winner's we/addr/wdata and pulse its gnt in the same cycle; go to ISSUE.
  - ISSUE: drive mem_addr and mem_wdata from the captured request for exactly one cycle.
    - Write: mem_write=1; go to DONE.
    - Read: mem_read=1; load the latency counter with READ_LATENCY-1; go to WAIT.
  - WAIT: if the counter is 0, capture mem_rdata into the winner's rdata register and go to DONE; otherwise decrement the counter.
  - DONE: pulse the winner's done for one cycle; update the last-winner pointer; go to IDLE.
- Latency, measured from the first req cycle when the arbiter is idle:
  - write: done at cycle +2;
  - read: done at cycle +2+READ_LATENCY.
  - Back-to-back transactions cost one additional IDLE cycle each.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the port not equal to last-winner wins (strict alternation).
  - A request that arrives while busy waits; it is not dropped.
- A requester must hold req, we, addr and wdata stable from assertion until its done pulse.
  - The arbiter samples them only at grant.
  - Deasserting req after grant does not abort the transaction.
- rdata registers hold their value until that port's next read completes.
- Addresses pass through unmodified. Alignment and byte enables belong to data memory, not this block.
- The p0 and p1 gnt/done signals are never high in the same cycle.
- mem_read and mem_write are never both high.
- Asynchronous reset mid-transaction returns to IDLE immediately. The in-flight access is abandoned with no done pulse, and the requester re-issues it.
- Simultaneous req from both ports in the same cycle the previous winner's done pulses: DONE leads to IDLE, then the next cycle arbitrates with the updated pointer.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ISSUE, WAIT, DONE as a 2-bit enum);
  - port-index constants PORT_PIPE=0, PORT_LOAD=1;
  - default width constants.
- One natural sub-module: rr_arbiter2. It is a combinational 2-way round-robin pick given the req vector and the last-winner bit, and outputs a one-hot win. The FSM and datapath capture stay in dmem_arbiter.

Test Plan:
- Write only on p0: p0_req=1, we=1, addr=0x10, wdata=0xDEADBEEF.
  - Expect p0_gnt at cycle 0, mem_write=1 with addr 0x10 at cycle 1, p0_done at cycle 2.
  - pipe_stall is high during cycles 0-1 and low at cycle 2.
- Read on p1 with READ_LATENCY=3, where memory returns 0x12345678 for addr 0x20.
  - Expect p1_done at cycle 5 with p1_rdata=0x12345678.
  - mem_read is high only in cycle 1.
- Contention: p0 and p1 both request reads right after reset.
  - Order is p0 then p1.
  - Then both re-request; order is p0 then p1 again. Gnt and done never overlap.
- Late arrival: p1 asserts req while p0's read is in WAIT.
  - p1 is granted in the IDLE cycle after p0_done.
  - p0's rdata is unchanged by p1's write.
- Reset mid-WAIT: assert reset low during WAIT of a p0 read.
  - All outputs go to 0 asynchronously with no p0_done.
  - After release, p0 re-requests and completes normally.
- Sweep READ_LATENCY over 1, 2 and 15: read done arrives at exactly cycle 2+READ_LATENCY.
